// File: rtl/gerenciador_chamadas_if.sv
// gerenciador_chamadas_if: call-manager bundle between buttons, movement controller, capacity monitor and the call manager
//   master (call manager): botao_andar, andar_atual, chegada, lotado in;
//                          destino, destino_valido, porta_aberta, chamadas_pendentes, subindo, ocioso out
//   slave  (environment):  mirror image of master
`timescale 1ns/1ps
interface gerenciador_chamadas_if;
    logic [3:0] botao_andar;
    logic [1:0] andar_atual;
    logic       chegada;
    logic       lotado;
    logic [1:0] destino;
    logic       destino_valido;
    logic       porta_aberta;
    logic [3:0] chamadas_pendentes;
    logic       subindo;
    logic       ocioso;
    modport master (
        input  botao_andar, andar_atual, chegada, lotado,
        output destino, destino_valido, porta_aberta, chamadas_pendentes, subindo, ocioso
    );
    modport slave (
        output botao_andar, andar_atual, chegada, lotado,
        input  destino, destino_valido, porta_aberta, chamadas_pendentes, subindo, ocioso
    );
endinterface

// File: rtl/gerenciador_chamadas.sv
// gerenciador_chamadas: latches floor calls, picks the next target with a SCAN policy, dispatches it and times the door
//   clock, reset : divided clock, asynchronous active-high reset
//   bus (master) : call buttons, current floor, arrival pulse and full flag in;
//                  target/valid handshake, door, pending calls, direction and idle flag out
`timescale 1ns/1ps
module gerenciador_chamadas #(
    parameter int TEMPO_PORTA = 4,
    parameter int LARG_TEMPO  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    gerenciador_chamadas_if.master bus
);
    typedef enum logic [1:0] {OCIOSO, ESCOLHE, DESPACHA, PORTA} estado_t;
    localparam logic [LARG_TEMPO-1:0] CARGA = LARG_TEMPO'(TEMPO_PORTA);
    estado_t               estado;
    logic [LARG_TEMPO-1:0] cont;
    logic [3:0]            botao_ant, pend, borda, sel_atual, acima, abaixo, seta, limpa;
    logic [1:0]            destino, alvo_acima, alvo_abaixo;
    logic                  destino_valido, porta_aberta, subindo, ocioso;
    logic                  vai_subir, vai_descer, chegou, reabre;
    always_comb begin
        borda       = bus.botao_andar & ~botao_ant;
        sel_atual   = 4'b0001 << bus.andar_atual;
        acima       = '0;
        abaixo      = '0;
        alvo_acima  = '0;
        alvo_abaixo = '0;
        for (int i = 0; i < 4; i++) begin
            acima[i]  = pend[i] && (2'(i) > bus.andar_atual);
            abaixo[i] = pend[i] && (2'(i) < bus.andar_atual);
        end
        // nearest call above is the lowest set bit, nearest below the highest
        for (int i = 3; i >= 0; i--) if (acima[i]) alvo_acima = 2'(i);
        for (int i = 0; i < 4; i++) if (abaixo[i]) alvo_abaixo = 2'(i);
        // keep the current direction while it has work, reverse only when it runs dry
        vai_subir  = subindo ? |acima : (~|abaixo && |acima);
        vai_descer = subindo ? (~|acima && |abaixo) : |abaixo;
        // a press for the floor whose door is open just keeps the door open
        reabre = (estado == PORTA) && |(borda & sel_atual);
        seta   = (estado == PORTA) ? (borda & ~sel_atual) : borda;
        chegou = (estado == DESPACHA) && bus.chegada && (bus.andar_atual == destino);
        limpa  = chegou ? (4'b0001 << destino) :
                 ((estado == ESCOLHE) && !vai_subir && !vai_descer) ? sel_atual : 4'b0000;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado         <= OCIOSO;
            cont           <= '0;
            botao_ant      <= '0;
            pend           <= '0;
            destino        <= '0;
            destino_valido <= 1'b0;
            porta_aberta   <= 1'b0;
            subindo        <= 1'b1;
            ocioso         <= 1'b1;
        end else begin
            botao_ant <= bus.botao_andar;
            pend      <= (pend | seta) & ~limpa;
            case (estado)
                OCIOSO:
                    if (|pend) begin
                        estado <= ESCOLHE;
                        ocioso <= 1'b0;
                    end
                ESCOLHE:
                    if (vai_subir || vai_descer) begin
                        destino        <= vai_subir ? alvo_acima : alvo_abaixo;
                        subindo        <= vai_subir;
                        destino_valido <= 1'b1;
                        estado         <= DESPACHA;
                    end else if (|(pend & sel_atual)) begin
                        cont         <= CARGA;
                        porta_aberta <= 1'b1;
                        estado       <= PORTA;
                    end else begin
                        estado <= OCIOSO;
                        ocioso <= 1'b1;
                    end
                DESPACHA:
                    if (chegou) begin
                        destino_valido <= 1'b0;
                        porta_aberta   <= 1'b1;
                        cont           <= CARGA;
                        estado         <= PORTA;
                    end
                PORTA:
                    // closing on the 1->0 step keeps the door open exactly TEMPO_PORTA cycles
                    if (reabre) cont <= CARGA;
                    else if (cont > LARG_TEMPO'(1)) cont <= cont - 1'b1;
                    else begin
                        cont <= '0;
                        if (!bus.lotado) begin
                            porta_aberta <= 1'b0;
                            estado       <= |pend ? ESCOLHE : OCIOSO;
                            ocioso       <= ~|pend;
                        end
                    end
                default: estado <= OCIOSO;
            endcase
        end
    end
    assign bus.destino            = destino;
    assign bus.destino_valido     = destino_valido;
    assign bus.porta_aberta       = porta_aberta;
    assign bus.chamadas_pendentes = pend;
    assign bus.subindo            = subindo;
    assign bus.ocioso             = ocioso;
endmodule
